// File: rtl/crack_scheduler_if.sv
// Scheduler-side bus for crack_scheduler: host start/result handshake plus two worker lanes.
// keys_tried is present only when CRACK_SCHED_PERF_EN is defined.
`timescale 1ns/1ps
interface crack_scheduler_if;
   logic             en;
   logic             rdy;
   logic [23:0]      key_start;
   logic [23:0]      key_end;
   logic [23:0]      key;
   logic             key_valid;
   logic [1:0]       w_en;
   logic [1:0][23:0] w_key;
   logic [1:0]       w_rdy;
   logic [1:0]       w_done;
   logic [1:0]       w_match;
`ifdef CRACK_SCHED_PERF_EN
   logic [24:0]      keys_tried;
`endif

   modport master (
      output en, key_start, key_end, w_rdy, w_done, w_match,
      input  rdy, key, key_valid, w_en, w_key
`ifdef CRACK_SCHED_PERF_EN
      , input keys_tried
`endif
   );

   modport slave (
      input  en, key_start, key_end, w_rdy, w_done, w_match,
      output rdy, key, key_valid, w_en, w_key
`ifdef CRACK_SCHED_PERF_EN
      , output keys_tried
`endif
   );
endinterface

// File: rtl/crack_scheduler.sv
// Hands ascending keys to two workers and reports the smallest matching key in the range.
// Optional keys_tried counter enabled by defining CRACK_SCHED_PERF_EN.
`timescale 1ns/1ps
module crack_scheduler (
   input  logic             clk,
   input  logic             rst_n,
   crack_scheduler_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StDispatch, StDrain, StDone} state_e;

   state_e           state_q, state_d;
   logic [23:0]      key_end_q, key_end_d;
   logic [24:0]      next_key_q, next_key_d;
   logic [23:0]      best_q, best_d;
   logic             found_q, found_d;
   logic [1:0]       outst_q, outst_d;
   logic [1:0][23:0] w_key_q, w_key_d;
   logic [23:0]      key_q, key_d;
   logic             key_valid_q, key_valid_d;

   logic        accept;
   logic        in_range;
   logic        can_issue;
   logic [1:0]  free;
   logic [1:0]  w_en_c;
   logic [1:0]  done_v;
   logic [1:0]  match_v;
   logic [23:0] cand;

   // Dispatch and completion decode
   always_comb begin
      accept    = (state_q == StIdle) && bus.en;
      // 25-bit compare so key_end = 24'hFFFFFF terminates without wrapping
      in_range  = (next_key_q <= {1'b0, key_end_q});
      can_issue = (state_q == StDispatch) && !found_q && in_range;
      free      = bus.w_rdy & ~outst_q;
      w_en_c    = 2'b00;
      if (can_issue) begin
         if (free[0]) begin
            w_en_c = 2'b01;
         end else if (free[1]) begin
            w_en_c = 2'b10;
         end
      end
      done_v  = bus.w_done & outst_q;
      match_v = done_v & bus.w_match;
      if (match_v == 2'b11) begin
         cand = (w_key_q[1] < w_key_q[0]) ? w_key_q[1] : w_key_q[0];
      end else if (match_v[1]) begin
         cand = w_key_q[1];
      end else begin
         cand = w_key_q[0];
      end
   end

   always_comb begin
      state_d     = state_q;
      key_end_d   = key_end_q;
      next_key_d  = next_key_q + {24'd0, |w_en_c};
      best_d      = best_q;
      found_d     = found_q;
      outst_d     = (outst_q & ~done_v) | w_en_c;
      key_d       = key_q;
      key_valid_d = key_valid_q;
      for (int i = 0; i < 2; i++) begin
         w_key_d[i] = w_en_c[i] ? next_key_q[23:0] : w_key_q[i];
      end

      if (|match_v) begin
         best_d  = (found_q && (best_q < cand)) ? best_q : cand;
         found_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               key_end_d  = bus.key_end;
               next_key_d = {1'b0, bus.key_start};
               best_d     = '0;
               found_d    = 1'b0;
               state_d    = (bus.key_start > bus.key_end) ? StDone : StDispatch;
            end
         end
         StDispatch: begin
            if (found_q || !in_range) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (outst_q == 2'b00) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Result is final on entry to DONE: nothing is outstanding by then
      if ((state_d == StDone) && (state_q != StDone)) begin
         key_d       = best_d;
         key_valid_d = found_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         key_end_q   <= '0;
         next_key_q  <= '0;
         best_q      <= '0;
         found_q     <= 1'b0;
         outst_q     <= '0;
         w_key_q     <= '0;
         key_q       <= '0;
         key_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_end_q   <= key_end_d;
         next_key_q  <= next_key_d;
         best_q      <= best_d;
         found_q     <= found_d;
         outst_q     <= outst_d;
         w_key_q     <= w_key_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
      end
   end

   assign bus.rdy       = (state_q == StIdle);
   assign bus.key       = key_q;
   assign bus.key_valid = key_valid_q;
   assign bus.w_en      = w_en_c;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         bus.w_key[i] = w_en_c[i] ? next_key_q[23:0] : w_key_q[i];
      end
   end

`ifdef CRACK_SCHED_PERF_EN
   logic [24:0] keys_tried_q, keys_tried_d;

   always_comb begin
      keys_tried_d = keys_tried_q + 25'(done_v[0]) + 25'(done_v[1]);
      if (accept) begin
         keys_tried_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         keys_tried_q <= '0;
      end else begin
         keys_tried_q <= keys_tried_d;
      end
   end

   assign bus.keys_tried = keys_tried_q;
`endif
endmodule

// File: tb/tb_crack_scheduler.sv
// Directed bench for crack_scheduler with two behavioural worker models.
// Build with CRACK_SCHED_PERF_EN defined to also check keys_tried.
`timescale 1ns/1ps
module tb_crack_scheduler;
   localparam logic [24:0] NoKey = 25'h1FF_FFFF;

   logic clk;
   logic rst_n;

   crack_scheduler_if ifc ();

   crack_scheduler u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   int n_checks;
   int n_errors;

   // Worker model configuration and state
   int          base_lat [2];
   logic [24:0] slow_key;
   int          slow_lat;
   logic [24:0] match_a;
   logic [24:0] match_b;
   logic        mdl_clr;
   logic [1:0]  mdl_rdy;
   logic [1:0]  mdl_done;
   logic [1:0]  mdl_match;
   logic [1:0]  stray_done;
   logic [1:0]  stray_match;
   logic [1:0]  busy;
   logic [1:0]  pend;
   logic [23:0] cur_key  [2];
   logic [23:0] pend_key [2];
   int          cnt      [2];
   int          en_cnt;
   int          hold_err;
   logic [23:0] max_key;
   logic [1:0]       en_s;
   logic [1:0][23:0] key_s;

   assign ifc.w_rdy   = mdl_rdy;
   assign ifc.w_done  = mdl_done | stray_done;
   assign ifc.w_match = mdl_match | stray_match;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lat_of(input int i, input logic [23:0] k);
      return ({1'b0, k} == slow_key) ? slow_lat : base_lat[i];
   endfunction

   function automatic logic is_match(input logic [23:0] k);
      return ({1'b0, k} == match_a) || ({1'b0, k} == match_b);
   endfunction

   // Worker w_en seen at one negedge is taken by the DUT at the next posedge
   always @(negedge clk) begin
      en_s  = ifc.w_en;
      key_s = ifc.w_key;
      if (mdl_clr || !rst_n) begin
         for (int i = 0; i < 2; i++) begin
            busy[i] = 1'b0; pend[i] = 1'b0; cnt[i] = 0;
            mdl_rdy[i] = 1'b1; mdl_done[i] = 1'b0; mdl_match[i] = 1'b0;
         end
         if (mdl_clr) begin
            en_cnt = 0; hold_err = 0; max_key = '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            mdl_done[i]  = 1'b0;
            mdl_match[i] = 1'b0;
            if (busy[i] && (key_s[i] != cur_key[i])) hold_err++;
            if (pend[i]) begin
               pend[i] = 1'b0; busy[i] = 1'b1; cur_key[i] = pend_key[i];
               cnt[i] = lat_of(i, pend_key[i]); mdl_rdy[i] = 1'b0;
            end else if (busy[i]) begin
               cnt[i]--;
               if (cnt[i] == 0) begin
                  busy[i] = 1'b0; mdl_rdy[i] = 1'b1;
                  mdl_done[i] = 1'b1; mdl_match[i] = is_match(cur_key[i]);
               end
            end
            if (en_s[i]) begin
               pend[i] = 1'b1; pend_key[i] = key_s[i]; en_cnt++;
               if (key_s[i] > max_key) max_key = key_s[i];
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clr_model();
      @(posedge clk); mdl_clr = 1'b1;
      @(posedge clk); mdl_clr = 1'b0;
   endtask

   task automatic run_search(input logic [23:0] s, input logic [23:0] e, input bit poke);
      int n;
      clr_model();
      @(negedge clk);
      ifc.en = 1'b1; ifc.key_start = s; ifc.key_end = e;
      @(negedge clk);
      ifc.en = 1'b0;
      n = 0;
      while (!ifc.rdy && (n < 1000)) begin
         // en while busy must be ignored
         if (poke && (n == 3)) begin
            ifc.en = 1'b1; ifc.key_start = 24'h0; ifc.key_end = 24'h0;
         end else begin
            ifc.en = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      ifc.en = 1'b0;
      chk("search_done", 32'(ifc.rdy), 32'd1);
   endtask

   initial begin
      int base_cnt;
      logic [1:0] wen_seen;
      n_checks = 0; n_errors = 0;
      rst_n = 1'b0; mdl_clr = 1'b0;
      ifc.en = 1'b0; ifc.key_start = '0; ifc.key_end = '0;
      stray_done = '0; stray_match = '0;
      base_lat[0] = 3; base_lat[1] = 3;
      slow_key = NoKey; slow_lat = 10; match_a = NoKey; match_b = NoKey;

      repeat (3) @(negedge clk);
      chk("rst_rdy", 32'(ifc.rdy), 32'd1);
      chk("rst_key", 32'(ifc.key), 32'd0);
      chk("rst_key_valid", 32'(ifc.key_valid), 32'd0);
      chk("rst_w_en", 32'(ifc.w_en), 32'd0);
      chk("rst_w_key0", 32'(ifc.w_key[0]), 32'd0);
      chk("rst_w_key1", 32'(ifc.w_key[1]), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk("idle_rdy", 32'(ifc.rdy), 32'd1);

      // Range 0..0x3F, single match at 0x18
      match_a = 25'h18;
      run_search(24'h0, 24'h3F, 1'b0);
      chk("m18_key", 32'(ifc.key), 32'h18);
      chk("m18_valid", 32'(ifc.key_valid), 32'd1);
      chk("m18_issued", 32'(en_cnt), 32'd26);
      chk("m18_max_key", 32'(max_key), 32'h19);
      chk("m18_hold", 32'(hold_err), 32'd0);
      repeat (5) @(negedge clk);
      chk("m18_key_held", 32'(ifc.key), 32'h18);
      chk("m18_valid_held", 32'(ifc.key_valid), 32'd1);

      // Empty range goes straight to DONE
      match_a = NoKey;
      run_search(24'h5, 24'h4, 1'b0);
      chk("empty_valid", 32'(ifc.key_valid), 32'd0);
      chk("empty_key", 32'(ifc.key), 32'd0);
      chk("empty_issued", 32'(en_cnt), 32'd0);

      // No match in 0x10..0x1F, with an ignored en mid-search
      run_search(24'h10, 24'h1F, 1'b1);
      chk("nomatch_valid", 32'(ifc.key_valid), 32'd0);
      chk("nomatch_issued", 32'(en_cnt), 32'd16);
      chk("nomatch_max_key", 32'(max_key), 32'h1F);
      chk("nomatch_hold", 32'(hold_err), 32'd0);
`ifdef CRACK_SCHED_PERF_EN
      chk("nomatch_tried", 32'(ifc.keys_tried), 32'd16);
`endif

      // Slow worker0 on 0x20, fast worker1 matches 0x21
      slow_key = 25'h20; slow_lat = 10; base_lat[1] = 2;
      match_a = 25'h21; match_b = 25'h20;
      run_search(24'h20, 24'h3F, 1'b0);
      chk("drain_both_key", 32'(ifc.key), 32'h20);
      chk("drain_both_valid", 32'(ifc.key_valid), 32'd1);
      chk("drain_both_issued", 32'(en_cnt), 32'd2);
      match_b = NoKey;
      run_search(24'h20, 24'h3F, 1'b0);
      chk("drain_one_key", 32'(ifc.key), 32'h21);
      chk("drain_one_hold", 32'(hold_err), 32'd0);
`ifdef CRACK_SCHED_PERF_EN
      chk("drain_one_tried", 32'(ifc.keys_tried), 32'd2);
`endif

      // Simultaneous matches on 0x30 and 0x31
      slow_key = NoKey; base_lat[0] = 4; base_lat[1] = 3;
      match_a = 25'h31; match_b = 25'h30;
      run_search(24'h30, 24'h3F, 1'b0);
      chk("same_cycle_key", 32'(ifc.key), 32'h30);
      chk("same_cycle_issued", 32'(en_cnt), 32'd2);

      // Top of key space
      base_lat[0] = 3; base_lat[1] = 3; match_a = NoKey; match_b = NoKey;
      run_search(24'hFFFFFE, 24'hFFFFFF, 1'b0);
      chk("top_valid", 32'(ifc.key_valid), 32'd0);
      chk("top_issued", 32'(en_cnt), 32'd2);
      chk("top_max_key", 32'(max_key), 32'hFFFFFF);

      // Reset in the middle of DISPATCH
      clr_model();
      @(negedge clk);
      ifc.en = 1'b1; ifc.key_start = 24'h0; ifc.key_end = 24'h3F;
      @(negedge clk);
      ifc.en = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_rdy", 32'(ifc.rdy), 32'd1);
      chk("midrst_w_en", 32'(ifc.w_en), 32'd0);
      chk("midrst_w_key0", 32'(ifc.w_key[0]), 32'd0);
`ifdef CRACK_SCHED_PERF_EN
      chk("midrst_tried", 32'(ifc.keys_tried), 32'd0);
`endif
      @(negedge clk); rst_n = 1'b1;
      base_cnt = en_cnt;
      @(negedge clk); stray_done = 2'b11; stray_match = 2'b11;
      @(negedge clk); stray_done = 2'b00; stray_match = 2'b00;
      wen_seen = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         wen_seen = wen_seen | ifc.w_en;
      end
      chk("stray_w_en", 32'(wen_seen), 32'd0);
      chk("stray_issued", 32'(en_cnt - base_cnt), 32'd0);
      chk("stray_rdy", 32'(ifc.rdy), 32'd1);
      chk("stray_valid", 32'(ifc.key_valid), 32'd0);

      // Normal operation after reset
      match_a = 25'h2;
      run_search(24'h0, 24'h3, 1'b0);
      chk("recover_key", 32'(ifc.key), 32'h2);
      chk("recover_valid", 32'(ifc.key_valid), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/crack_scheduler.md
CRACK_SCHEDULER -- requirements
Module: crack_scheduler

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port en, input, 1: start request; sampled only while rdy=1.
REQ-004 SHALL have port rdy, output, 1: idle and able to accept en.
REQ-005 SHALL have port key_start, input, 24: first key of the search range; sampled on the accepting edge.
REQ-006 SHALL have port key_end, input, 24: last key of the search range, inclusive; sampled on the accepting edge.
REQ-007 SHALL have port key, output, 24: result key; valid when rdy=1 after a completed search.
REQ-008 SHALL have port key_valid, output, 1: 1 means key holds a matching key.
REQ-009 SHALL have port w_en, output, 2: per-worker one-cycle start pulse.
REQ-010 SHALL have port w_key, output, 2x24 packed: per-worker key, held stable from the w_en pulse until that worker's w_done.
REQ-011 SHALL have port w_rdy, input, 2: per-worker idle flag.
REQ-012 SHALL have port w_done, input, 2: per-worker one-cycle completion pulse.
REQ-013 SHALL have port w_match, input, 2: per-worker match result; qualified by w_done.

Function
REQ-014 SHALL implement states IDLE, DISPATCH, DRAIN, DONE.
REQ-015 SHALL accept a start on an edge with rdy=1 and en=1, latch the range, load a 25-bit next_key with key_start, clear the best-match register, and drive rdy=0 from the following cycle.
REQ-016 SHALL leave IDLE for DISPATCH on acceptance; if key_start>key_end it SHALL go directly to DONE with key_valid=0.
REQ-017 SHALL, in DISPATCH, issue at most one key per cycle: pulse w_en[i] for the lowest-index worker i with w_rdy[i]=1 and no key outstanding, drive w_key[i]=next_key, and increment next_key.
REQ-018 SHALL issue the first w_en on the cycle after acceptance, provided a worker is ready.
REQ-019 SHALL track one outstanding flag per worker: set on w_en[i], cleared on w_done[i]; a w_done without an outstanding key SHALL be ignored.
REQ-020 SHALL, on w_done[i]=1 with w_match[i]=1, set best = min(best, w_key[i]) and set the found flag.
REQ-021 SHALL, when both workers report a match on the same cycle, keep the numerically smaller key.
REQ-022 SHALL move from DISPATCH to DRAIN when the found flag is set, or when next_key>key_end; the 25-bit compare SHALL handle key_end=24'hFFFFFF with no wrap.
REQ-023 SHALL, in DRAIN, issue no w_en and wait until no worker has a key outstanding, then go to DONE. Because keys are issued in ascending order, the reported key is the smallest matching key in the range.
REQ-024 SHALL, in DONE, drive key=best and key_valid=found, then go to IDLE with rdy=1 on the next cycle.
REQ-025 SHALL hold key and key_valid stable in IDLE until the next accepted en.
REQ-026 SHALL ignore en while rdy=0.
REQ-027 SHALL keep w_en=0 in IDLE, DRAIN and DONE.

Reset
REQ-028 SHALL, on rst_n=0 and regardless of clk, force state=IDLE, rdy=1, key=0, key_valid=0, w_en=0, w_key=0, next_key=0, outstanding flags=0, found=0.
REQ-029 SHALL, on reset mid-search, discard all outstanding work; w_done pulses arriving after reset release SHALL be ignored.

Configuration
REQ-030 SHALL, when macro CRACK_SCHED_PERF_EN is defined, add output keys_tried (25 bits): cleared on an accepted en, incremented on each counted w_done, held after DONE.
REQ-031 SHALL, without CRACK_SCHED_PERF_EN, omit the keys_tried port and counter; all other behaviour SHALL be identical.

Verification
REQ-032 SHALL cover: reset, then en with range 0..0x3F, worker models match only at key 0x18 with 3-cycle latency -> key=0x000018, key_valid=1, rdy=1; no w_key above the last issued key.
REQ-033 SHALL cover: range 0x10..0x1F with no matching key -> key_valid=0; exactly 16 w_en pulses in total; keys_tried=16 when CRACK_SCHED_PERF_EN is defined.
REQ-034 SHALL cover: worker0 holds key 0x20 for 10 cycles, worker1 matches 0x21 after 2 cycles -> DRAIN waits for worker0; if 0x20 also matches, key=0x000020.
REQ-035 SHALL cover: both workers pulse w_done with match on the same cycle with keys 0x31 and 0x30 -> key=0x000030.
REQ-036 SHALL cover: key_start=0xFFFFFE, key_end=0xFFFFFF, no match -> exactly 2 keys issued, search terminates, key_valid=0.
REQ-037 SHALL cover: rst_n=0 asserted mid-DISPATCH -> rdy=1 and w_en=0 immediately; a later stray w_done causes no dispatch and no match.
